// File: rtl/anfield_fifo_pkg.sv
// Shared helpers for the synchronous flush FIFO: pointer sizing and the
// elaboration-time depth check.
`ifndef ANFIELD_FIFO_POW2_CHECK
`define ANFIELD_FIFO_POW2_CHECK(val) \
  if (!anfield_fifo_pkg::is_pow2(val)) begin : g_pow2_check \
    $error("sync_flush_fifo: Depth must be a power of two and at least 2"); \
  end
`endif

package anfield_fifo_pkg;

  // Pointer width: index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // True for powers of two that are at least 2.
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrap-bit pointer register. A clear has priority over an increment.
module fifo_ptr_ctr #(
  parameter int unsigned Width = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [Width-1:0] o_ptr
);

  logic [Width-1:0] r_ptr;

  // Pointer state: async reset, synchronous clear, else advance on inc.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + Width'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_flush_fifo.sv
// Synchronous show-ahead FIFO with occupancy, almost-full, overflow/underflow
// pulses and a synchronous flush for pipeline redirects.
module sync_flush_fifo
  import anfield_fifo_pkg::*;
#(
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned Depth           = 4,
  parameter int unsigned AlmostFullLevel = Depth - 1,
  localparam int unsigned PtrW           = ptr_width(Depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic                 i_winc,
  output logic                 o_wfull,
  output logic                 o_walmost_full,
  output logic                 o_woverflow,
  output logic [DataWidth-1:0] o_rdata,
  input  logic                 i_rinc,
  output logic                 o_rempty,
  output logic                 o_runderflow,
  output logic [PtrW-1:0]      o_count,
  input  logic                 i_jump_flag
);

  localparam int unsigned AddrW = PtrW - 1;
  localparam logic [PtrW-1:0] AfLevel = PtrW'(AlmostFullLevel);

  `ANFIELD_FIFO_POW2_CHECK(Depth)

  if (AlmostFullLevel < 1 || AlmostFullLevel > Depth) begin : g_af_check
    $error("sync_flush_fifo: AlmostFullLevel must be in 1..Depth");
  end

  logic [PtrW-1:0]      w_wptr;
  logic [PtrW-1:0]      w_rptr;
  logic [AddrW-1:0]     w_waddr;
  logic [AddrW-1:0]     w_raddr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [PtrW-1:0]      w_count;
  logic                 r_woverflow;
  logic                 r_runderflow;
  logic [DataWidth-1:0] r_mem [Depth];

  assign w_waddr = w_wptr[AddrW-1:0];
  assign w_raddr = w_rptr[AddrW-1:0];

  // Status derived from registered pointers only.
  always_comb begin
    w_empty = (w_wptr == w_rptr);
    w_full  = (w_waddr == w_raddr) && (w_wptr[AddrW] != w_rptr[AddrW]);
    w_count = w_wptr - w_rptr;
  end

  // Accepts; a flush discards any same-cycle read or write.
  always_comb begin
    w_wr_en = i_winc && !w_full && !i_jump_flag;
    w_rd_en = i_rinc && !w_empty && !i_jump_flag;
  end

  fifo_ptr_ctr #(
    .Width (PtrW)
  ) u_wptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_wr_en),
    .i_clr   (i_jump_flag),
    .o_ptr   (w_wptr)
  );

  fifo_ptr_ctr #(
    .Width (PtrW)
  ) u_rptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_rd_en),
    .i_clr   (i_jump_flag),
    .o_ptr   (w_rptr)
  );

  // Storage: cleared on reset so the head reads zero, untouched by a flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_waddr] <= i_wdata;
    end
  end

  // Dropped-request pulses, computed from pre-flush flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_woverflow  <= 1'b0;
      r_runderflow <= 1'b0;
    end else begin
      r_woverflow  <= i_winc && w_full;
      r_runderflow <= i_rinc && w_empty;
    end
  end

  assign o_wfull        = w_full;
  assign o_rempty       = w_empty;
  assign o_count        = w_count;
  assign o_walmost_full = (w_count >= AfLevel);
  assign o_woverflow    = r_woverflow;
  assign o_runderflow   = r_runderflow;
  assign o_rdata        = r_mem[w_raddr];

endmodule

// File: doc/sync_flush_fifo.md
Name: sync_flush_fifo

Overview:
Parametrised synchronous FIFO that replaces the single-entry pipeline buffer, generalised to any power-of-two depth. It supports same-cycle read and write, reports occupancy and an almost-full threshold, and flags write overflow and read underflow. A flush input (JumpFlag) discards all buffered entries on pipeline redirect. It sits between fetch/decode-style pipeline stages.

Parameters:
DataWidth, 64, width of each entry in bits.
Depth, 4, number of entries; power of two, at least 2.
AlmostFullLevel, Depth-1, occupancy at or above which WAlmostFull is asserted; range 1..Depth.

Ports:
Clk  input  1  clock; all state updates on rising edge.
Rst  input  1  asynchronous active-low reset.
WData  input  DataWidth  write data.
WInc  input  1  write request.
WFull  output  1  FIFO holds Depth entries.
WAlmostFull  output  1  Count >= AlmostFullLevel.
WOverflow  output  1  one-cycle registered pulse: a write was dropped.
RData  output  DataWidth  head entry, show-ahead (valid whenever REmpty=0).
RInc  input  1  read request (pop the head).
REmpty  output  1  FIFO holds 0 entries.
RUnderflow  output  1  one-cycle registered pulse: a read was dropped.
Count  output  $clog2(Depth)+1  current occupancy, 0..Depth.
JumpFlag  input  1  synchronous flush.

Behaviour:
- Reset (Rst=0, asynchronous, independent of Clk): pointers=0, Count=0, REmpty=1, WFull=0, WAlmostFull=0, WOverflow=0, RUnderflow=0, and every storage entry=0, so RData=0.
- Pointers: WPtr/RPtr each $clog2(Depth)+1 bits (extra wrap bit). Empty when the pointers are equal. Full when the index bits are equal and the wrap bits differ. Count = WPtr - RPtr, modulo 2^(width).
- Write accept: WInc && !WFull. The entry is written at WPtr index and WPtr increments next edge. Writes are never accepted while full, even with a simultaneous RInc.
- Read accept: RInc && !REmpty. RPtr increments next edge.
- RData: combinational mem[RPtr index]. It is stable while REmpty=1 or RInc=0. There is zero latency from accept to visibility: a write into an empty FIFO gives REmpty=0 and RData=WData after that edge.
- Simultaneous accepted read and write: both pointers advance and Count is unchanged. At Depth-1 occupancy this is legal and Count stays at Depth-1.
- WOverflow: registered WInc && WFull, asserted for the next cycle only. RUnderflow: registered RInc && REmpty. Neither affects state.
- JumpFlag=1 at an edge: WPtr<=0 and RPtr<=0, so Count=0 and REmpty=1 next cycle. It has priority over WInc/RInc in the same cycle; that write and that read are both discarded. WOverflow/RUnderflow are still computed from pre-flush flags. Storage contents are not cleared (RData is don't-care while empty).
- Status outputs are derived combinationally from the registered pointers only. There is no combinational path from WInc/RInc/JumpFlag to any output.
- Pointer wrap: the index wraps modulo Depth and the wrap bit toggles. Sustained streaming must never report false full/empty.
- Reset asserted mid-transfer: immediate return to the reset state; any partial accept in that cycle is lost.

Decomposition:
- Shared package anfield_fifo_pkg: ptr_width(Depth) constant function ($clog2(Depth)+1) and a Depth power-of-two check macro (elaboration error otherwise).
- One sub-module, fifo_ptr_ctr: wrap-bit pointer register with inc/clear inputs and async active-low reset. It is instantiated twice (write/read).
- Storage is an inline reg array in the top.

Test Plan:
1. Reset with Rst=0 mid-cycle (no clock edge) -> REmpty=1, WFull=0, Count=0, RData=0 immediately. Release, then idle 3 cycles -> unchanged.
2. Depth=4: write 0xA0..0xA3 on 4 consecutive cycles -> Count 1,2,3,4; WAlmostFull at Count=3; WFull=1 after the 4th. A 5th WInc of 0xA4 -> dropped, WOverflow=1 for one cycle, Count=4.
3. From full, RInc for 4 cycles -> RData 0xA0,0xA1,0xA2,0xA3 in order, then REmpty=1. A further RInc -> RUnderflow pulse, Count=0.
4. Count=2, then WInc+RInc together for 10 cycles with incrementing data -> Count stays 2, output order is preserved across pointer wrap, no full/empty glitch.
5. Count=3, then JumpFlag=1 with WInc=1 (0xFF) and RInc=1 -> next cycle Count=0, REmpty=1. A subsequent write of 0x11 -> RData=0x11, Count=1.
6. Empty, then a single write of 0x5A -> REmpty=0 and RData=0x5A the following cycle. A same-cycle read and write at Count=1 -> RData advances to the new entry, Count=1.
